// File: rtl/chacha_block_core_pkg.sv
// rtl/chacha_block_core_pkg.sv - ChaCha constants, state types, FSM encoding and lane index tables
// Contents:
//   chacha_state_t  sixteen 32-bit state words, word i at [32i+31:32i]
//   chacha_fsm_e    block core control states
//   SIGMA           "expand 32-byte k" constant words 0..3
//   COL_IDX/DIAG_IDX  [lane][slot] -> state word index for column / diagonal rounds
//   rotl32          32-bit rotate left
//   build_state     assembles the initial state from key, nonce and counter
package chacha_pkg;

    typedef logic [15:0][31:0] chacha_state_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        OUT   = 2'd3
    } chacha_fsm_e;

    localparam logic [3:0][31:0] SIGMA = {
        32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865
    };

    // Slot order inside a lane is (a, b, c, d) of the quarter round.
    localparam logic [0:3][0:3][3:0] COL_IDX = {
        {4'd0, 4'd4, 4'd8,  4'd12},
        {4'd1, 4'd5, 4'd9,  4'd13},
        {4'd2, 4'd6, 4'd10, 4'd14},
        {4'd3, 4'd7, 4'd11, 4'd15}
    };

    localparam logic [0:3][0:3][3:0] DIAG_IDX = {
        {4'd0, 4'd5, 4'd10, 4'd15},
        {4'd1, 4'd6, 4'd11, 4'd12},
        {4'd2, 4'd7, 4'd8,  4'd13},
        {4'd3, 4'd4, 4'd9,  4'd14}
    };

    function automatic logic [31:0] rotl32(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic chacha_state_t build_state(input logic [255:0] key,
                                                  input logic [95:0]  nonce,
                                                  input logic [31:0]  counter);
        chacha_state_t s;
        s[3:0]   = SIGMA;
        s[11:4]  = key;
        s[12]    = counter;
        s[15:13] = nonce;
        return s;
    endfunction

endpackage

// File: rtl/chacha_block_core_if.sv
// rtl/chacha_block_core_if.sv - request and keystream handshake bundle for chacha_block_core
// master: requester/consumer side (drives start_valid, key, nonce, counter, ks_ready)
// slave:  block core side (drives start_ready, ks_valid, ks_data, busy)
interface chacha_block_core_if;

    logic         start_valid;
    logic         start_ready;
    logic [255:0] key;
    logic [95:0]  nonce;
    logic [31:0]  counter;
    logic         ks_valid;
    logic         ks_ready;
    logic [511:0] ks_data;
    logic         busy;

    modport master (
        output start_valid, key, nonce, counter, ks_ready,
        input  start_ready, ks_valid, ks_data, busy
    );

    modport slave (
        input  start_valid, key, nonce, counter, ks_ready,
        output start_ready, ks_valid, ks_data, busy
    );

endinterface

// File: rtl/chacha_block_core_quarter_round.sv
// rtl/chacha_block_core_quarter_round.sv - combinational ChaCha quarter round
// Ports: a_i/b_i/c_i/d_i  input words; a_o/b_o/c_o/d_o  output words
import chacha_pkg::*;

module quarter_round (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] c_i,
    input  logic [31:0] d_i,
    output logic [31:0] a_o,
    output logic [31:0] b_o,
    output logic [31:0] c_o,
    output logic [31:0] d_o
);

    logic [31:0] a1, b1, c1, d1;

    assign a1  = a_i + b_i;
    assign d1  = rotl32(d_i ^ a1, 16);
    assign c1  = c_i + d1;
    assign b1  = rotl32(b_i ^ c1, 12);
    assign a_o = a1 + b1;
    assign d_o = rotl32(d1 ^ a_o, 8);
    assign c_o = c1 + d_o;
    assign b_o = rotl32(b1 ^ c_o, 7);

endmodule

// File: rtl/chacha_block_core.sv
// rtl/chacha_block_core.sv - iterative ChaCha block function, one column/diagonal round per clock
// Ports: clk, rst_n (async active-low)
//        bus.slave: start_valid/start_ready + key/nonce/counter request,
//                   ks_valid/ks_ready + ks_data keystream block, busy
// Parameter ROUNDS: total single rounds, even and >= 2.
import chacha_pkg::*;

module chacha_block_core #(
    parameter int ROUNDS = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    chacha_block_core_if.slave  bus
);

    localparam int RW = (ROUNDS > 2) ? $clog2(ROUNDS) : 1;

    chacha_fsm_e   state_q, state_d;
    logic [RW-1:0] rnd_q, rnd_d;
    chacha_state_t work_q, work_d;
    chacha_state_t init_q, init_d;
    chacha_state_t ks_q, ks_d;
    logic          ks_valid_q, ks_valid_d;

    chacha_state_t   round_out;
    logic [3:0][31:0] qa, qb, qc, qd;
    logic [3:0][31:0] ra, rb, rc, rd;
    logic            diag;

    // Rounds alternate column/diagonal starting with column, so rnd LSB selects the lane map.
    assign diag = rnd_q[0];

    always_comb begin
        qa = '0;
        qb = '0;
        qc = '0;
        qd = '0;
        for (int l = 0; l < 4; l++) begin
            qa[l] = work_q[diag ? DIAG_IDX[l][0] : COL_IDX[l][0]];
            qb[l] = work_q[diag ? DIAG_IDX[l][1] : COL_IDX[l][1]];
            qc[l] = work_q[diag ? DIAG_IDX[l][2] : COL_IDX[l][2]];
            qd[l] = work_q[diag ? DIAG_IDX[l][3] : COL_IDX[l][3]];
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_qr
        quarter_round u_qr (
            .a_i (qa[g]),
            .b_i (qb[g]),
            .c_i (qc[g]),
            .d_i (qd[g]),
            .a_o (ra[g]),
            .b_o (rb[g]),
            .c_o (rc[g]),
            .d_o (rd[g])
        );
    end

    // Each of the 16 words belongs to exactly one lane in either map, so every word is rewritten.
    always_comb begin
        round_out = work_q;
        for (int l = 0; l < 4; l++) begin
            round_out[diag ? DIAG_IDX[l][0] : COL_IDX[l][0]] = ra[l];
            round_out[diag ? DIAG_IDX[l][1] : COL_IDX[l][1]] = rb[l];
            round_out[diag ? DIAG_IDX[l][2] : COL_IDX[l][2]] = rc[l];
            round_out[diag ? DIAG_IDX[l][3] : COL_IDX[l][3]] = rd[l];
        end
    end

    always_comb begin
        state_d    = state_q;
        rnd_d      = rnd_q;
        work_d     = work_q;
        init_d     = init_q;
        ks_d       = ks_q;
        ks_valid_d = ks_valid_q;
        case (state_q)
            IDLE: begin
                // start_ready is decoded from IDLE, so start_valid here is an accept.
                if (bus.start_valid) begin
                    state_d = ROUND;
                    rnd_d   = '0;
                    work_d  = build_state(bus.key, bus.nonce, bus.counter);
                    init_d  = build_state(bus.key, bus.nonce, bus.counter);
                end
            end
            ROUND: begin
                work_d = round_out;
                rnd_d  = rnd_q + 1'b1;
                if (rnd_q == RW'(ROUNDS - 1)) begin
                    state_d = FINAL;
                    rnd_d   = '0;
                end
            end
            FINAL: begin
                for (int i = 0; i < 16; i++) begin
                    ks_d[i] = work_q[i] + init_q[i];
                end
                ks_valid_d = 1'b1;
                state_d    = OUT;
            end
            OUT: begin
                if (bus.ks_ready) begin
                    ks_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rnd_q      <= '0;
            work_q     <= '0;
            init_q     <= '0;
            ks_q       <= '0;
            ks_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rnd_q      <= rnd_d;
            work_q     <= work_d;
            init_q     <= init_d;
            ks_q       <= ks_d;
            ks_valid_q <= ks_valid_d;
        end
    end

    assign bus.start_ready = (state_q == IDLE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.ks_valid    = ks_valid_q;
    assign bus.ks_data     = ks_q;

endmodule
